// File: rtl/move_sched.sv
// Draughts move generator: walks the four diagonal directions through a shared
// shifter and emits per-direction simple-move and jump-landing masks.
module move_sched #(
  parameter bit EMIT_EMPTY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] own,
  input  logic [31:0] opp,
  input  logic [31:0] kings,
  input  logic        player,
  output logic [1:0]  sh_dir,
  output logic [31:0] sh_in,
  input  logic [31:0] sh_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_dir,
  output logic [31:0] res_move,
  output logic [31:0] res_jump,
  output logic        busy,
  output logic        done,
  output logic        any_jump
);

  typedef enum logic [2:0] {StIdle, StSh1, StSh2, StEmit, StDone} state_e;

  state_e      state_q;
  logic [1:0]  d_q;
  logic [31:0] own_q, opp_q, kings_q;
  logic        player_q;
  logic [31:0] step_q, move_q, jump_q;
  logic        any_jump_q;

  logic [31:0] empty, movers, jump_nxt;
  logic        skip;

  assign empty    = ~(own_q | opp_q);
  // Men only move in the two directions facing the opponent; kings move in all four.
  assign movers   = (d_q[1] == player_q) ? own_q : (own_q & kings_q);
  assign jump_nxt = sh_out & empty;
  assign skip     = !EMIT_EMPTY && (move_q == '0) && (jump_nxt == '0);

  always_comb begin
    sh_dir = 2'd0;
    sh_in  = '0;
    case (state_q)
      StSh1: begin
        sh_dir = d_q;
        sh_in  = movers;
      end
      StSh2: begin
        sh_dir = d_q;
        sh_in  = step_q & opp_q;
      end
      default: ;
    endcase
  end

  assign res_valid = (state_q == StEmit);
  assign res_dir   = d_q;
  assign res_move  = move_q;
  assign res_jump  = jump_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign any_jump  = any_jump_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      d_q        <= 2'd0;
      own_q      <= '0;
      opp_q      <= '0;
      kings_q    <= '0;
      player_q   <= 1'b0;
      step_q     <= '0;
      move_q     <= '0;
      jump_q     <= '0;
      any_jump_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            own_q      <= own;
            opp_q      <= opp;
            kings_q    <= kings;
            player_q   <= player;
            any_jump_q <= 1'b0;
            d_q        <= 2'd0;
            state_q    <= StSh1;
          end
        end
        StSh1: begin
          step_q  <= sh_out;
          move_q  <= sh_out & empty;
          state_q <= StSh2;
        end
        StSh2: begin
          jump_q <= jump_nxt;
          if (!skip) begin
            state_q <= StEmit;
          end else if (d_q == 2'd3) begin
            state_q <= StDone;
          end else begin
            d_q     <= d_q + 2'd1;
            state_q <= StSh1;
          end
        end
        StEmit: begin
          if (res_ready) begin
            any_jump_q <= any_jump_q | (|jump_q);
            if (d_q == 2'd3) begin
              state_q <= StDone;
            end else begin
              d_q     <= d_q + 2'd1;
              state_q <= StSh1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sched.sv
// Bench for move_sched: two instances (emit-all and skip-empty) driven in lockstep,
// checked against a per-pass beat list computed from the move rules.
module tb_move_sched;

  typedef struct packed {
    logic [1:0]  dir;
    logic [31:0] mv;
    logic [31:0] jp;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset, start, player, res_ready, stub;
  logic [31:0] own, opp, kings;

  logic [1:0]  sh_dir0, sh_dir1, res_dir0, res_dir1;
  logic [31:0] sh_in0, sh_in1, sh_out0, sh_out1;
  logic [31:0] res_move0, res_move1, res_jump0, res_jump1;
  logic        res_valid0, res_valid1, busy0, busy1, done0, done1, any_jump0, any_jump1;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t exp_arr[2][4];
  beat_t got[2][4];
  beat_t h[2];
  int    exp_n[2], exp_rd[2], got_n[2], cyc[2], stall[2], last_cyc[2];
  logic  last_any[2];
  logic  held[2];
  logic  exp_any;
  logic  pass_active[2];

  always #5 clock = ~clock;

  function automatic logic [31:0] shf(input logic [1:0] dir, input logic [31:0] x,
                                      input logic st);
    if (st) return x << 4;
    case (dir)
      2'd0:    return x << 4;
      2'd1:    return x << 5;
      2'd2:    return x >> 4;
      default: return x >> 3;
    endcase
  endfunction

  assign sh_out0 = shf(sh_dir0, sh_in0, stub);
  assign sh_out1 = shf(sh_dir1, sh_in1, stub);

  move_sched #(.EMIT_EMPTY(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .own(own), .opp(opp), .kings(kings),
    .player(player), .sh_dir(sh_dir0), .sh_in(sh_in0), .sh_out(sh_out0),
    .res_valid(res_valid0), .res_ready(res_ready), .res_dir(res_dir0),
    .res_move(res_move0), .res_jump(res_jump0), .busy(busy0), .done(done0),
    .any_jump(any_jump0)
  );

  move_sched #(.EMIT_EMPTY(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .own(own), .opp(opp), .kings(kings),
    .player(player), .sh_dir(sh_dir1), .sh_in(sh_in1), .sh_out(sh_out1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_dir(res_dir1),
    .res_move(res_move1), .res_jump(res_jump1), .busy(busy1), .done(done1),
    .any_jump(any_jump1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected beats for the operands currently on the inputs (already latched by the DUTs).
  task automatic build_model();
    logic [31:0] empty, mv, stp, mo, ju;
    bit          allowed;
    exp_any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_n[i] = 0; exp_rd[i] = 0; got_n[i] = 0; cyc[i] = 0; stall[i] = 0; held[i] = 1'b0;
    end
    empty = ~(own | opp);
    for (int d = 0; d < 4; d++) begin
      allowed = player ? (d >= 2) : (d < 2);
      mv  = allowed ? own : (own & kings);
      stp = shf(2'(d), mv, stub);
      mo  = stp & empty;
      ju  = shf(2'(d), stp & opp, stub) & empty;
      exp_any = exp_any | (ju != 0);
      exp_arr[1][exp_n[1]] = '{dir: 2'(d), mv: mo, jp: ju};
      exp_n[1]++;
      if (mo != 0 || ju != 0) begin
        exp_arr[0][exp_n[0]] = '{dir: 2'(d), mv: mo, jp: ju};
        exp_n[0]++;
      end
    end
  endtask

  task automatic monitor(input int i, input logic valid, input logic ready,
                         input logic [1:0] dir, input logic [31:0] mv, input logic [31:0] jp,
                         input logic dn, input logic aj, input logic bz);
    if (reset) begin
      held[i] = 1'b0;
      return;
    end
    chk($sformatf("busy%0d", i), 32'(bz), 32'(pass_active[i]));
    if (!pass_active[i]) chk($sformatf("any_jump_hold%0d", i), 32'(aj), 32'(exp_any));
    if (pass_active[i]) cyc[i]++;
    if (held[i]) begin
      chk($sformatf("hold_valid%0d", i), 32'(valid), 32'd1);
      chk($sformatf("hold_dir%0d", i), 32'(dir), 32'(h[i].dir));
      chk($sformatf("hold_move%0d", i), mv, h[i].mv);
      chk($sformatf("hold_jump%0d", i), jp, h[i].jp);
    end
    if (valid) begin
      if (exp_rd[i] >= exp_n[i]) begin
        chk($sformatf("extra_beat%0d", i), 32'(exp_rd[i] + 1), 32'(exp_n[i]));
      end else if (ready) begin
        chk($sformatf("beat_dir%0d", i), 32'(dir), 32'(exp_arr[i][exp_rd[i]].dir));
        chk($sformatf("beat_move%0d", i), mv, exp_arr[i][exp_rd[i]].mv);
        chk($sformatf("beat_jump%0d", i), jp, exp_arr[i][exp_rd[i]].jp);
        got[i][got_n[i]] = '{dir: dir, mv: mv, jp: jp};
        got_n[i]++;
        exp_rd[i]++;
      end else begin
        stall[i]++;
      end
    end
    held[i] = valid && !ready;
    h[i]    = '{dir: dir, mv: mv, jp: jp};
    if (dn) begin
      chk($sformatf("done_cycle%0d", i), 32'(cyc[i]), 32'(9 + exp_n[i] + stall[i]));
      chk($sformatf("beats_left%0d", i), 32'(exp_rd[i]), 32'(exp_n[i]));
      chk($sformatf("any_jump%0d", i), 32'(aj), 32'(exp_any));
      last_cyc[i]    = cyc[i];
      last_any[i]    = aj;
      pass_active[i] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    monitor(0, res_valid0, res_ready, res_dir0, res_move0, res_jump0, done0, any_jump0, busy0);
    monitor(1, res_valid1, res_ready, res_dir1, res_move1, res_jump1, done1, any_jump1, busy1);
  end

  // mode 0: ready high; 1: random ready; 2: ready low for the first 5 EMIT cycles.
  task automatic run_pass(input int mode, input bit junk);
    int budget;
    int stall_left;
    start = 1'b1;
    step();
    start = 1'b0;
    build_model();
    pass_active[0] = 1'b1;
    pass_active[1] = 1'b1;
    stall_left = 5;
    budget = 0;
    while ((pass_active[0] || pass_active[1]) && budget < 200) begin
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (res_valid1 && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
      if (junk && pass_active[0] && pass_active[1] && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        own   = $urandom;
        opp   = $urandom;
      end else begin
        start = 1'b0;
      end
      step();
      budget++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    if (budget >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL pass_timeout: got no done within %0d cycles, expected done", budget);
      pass_active[0] = 1'b0;
      pass_active[1] = 1'b0;
    end
  endtask

  initial begin
    int budget;
    pass_active[0] = 1'b0; pass_active[1] = 1'b0;
    held[0] = 1'b0; held[1] = 1'b0;
    exp_any = 1'b0;
    reset = 1'b1; start = 1'b0; res_ready = 1'b1; stub = 1'b1;
    own = '0; opp = '0; kings = '0; player = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_valid", 32'(res_valid1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_any_jump", 32'(any_jump1), 32'd0);
    chk("rst_sh_in", sh_in1, 32'd0);
    chk("rst_sh_dir", 32'(sh_dir1), 32'd0);

    // Single man, empty board, shift-by-4 stub.
    own = 32'h1; opp = '0; kings = '0; player = 1'b0;
    run_pass(0, 1'b0);
    chk("p1_done_cycle", 32'(last_cyc[1]), 32'd13);
    chk("p1_d0_move", got[1][0].mv, 32'h10);
    chk("p1_d0_jump", got[1][0].jp, 32'h0);
    chk("p1_d1_move", got[1][1].mv, 32'h10);
    chk("p1_d2_move", got[1][2].mv, 32'h0);
    chk("p1_d3_dir", 32'(got[1][3].dir), 32'd3);
    chk("p1_d3_move", got[1][3].mv, 32'h0);
    chk("p1_any_jump", 32'(last_any[1]), 32'd0);
    chk("p1_skip_done_cycle", 32'(last_cyc[0]), 32'd11);

    // Opponent in front: jump, no simple move.
    own = 32'h1; opp = 32'h10;
    run_pass(0, 1'b0);
    chk("p2_d0_move", got[1][0].mv, 32'h0);
    chk("p2_d0_jump", got[1][0].jp, 32'h100);
    chk("p2_any_jump", 32'(last_any[1]), 32'd1);

    // Nothing to move: skip-empty instance emits nothing.
    own = '0; opp = '0;
    run_pass(0, 1'b0);
    chk("p3_skip_done_cycle", 32'(last_cyc[0]), 32'd9);
    chk("p3_skip_beats", 32'(got_n[0]), 32'd0);

    // Five-cycle consumer stall in d0 with spurious start pulses.
    own = 32'h1; opp = '0;
    run_pass(2, 1'b1);
    chk("p4_done_cycle", 32'(last_cyc[1]), 32'd18);
    chk("p4_skip_done_cycle", 32'(last_cyc[0]), 32'd16);
    chk("p4_d0_move", got[1][0].mv, 32'h10);

    // Reset while the d2 beat is on the bus.
    own = 32'h1; opp = 32'h10; res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    build_model();
    pass_active[0] = 1'b1; pass_active[1] = 1'b1;
    budget = 0;
    while (!(res_valid1 && res_dir1 == 2'd2) && budget < 50) begin
      step();
      budget++;
    end
    chk("reach_d2_emit", 32'(res_valid1), 32'd1);
    chk("pre_rst_any_jump", 32'(any_jump1), 32'd1);
    reset = 1'b1; start = 1'b1; res_ready = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    pass_active[0] = 1'b0; pass_active[1] = 1'b0;
    exp_any = 1'b0; exp_n[0] = 0; exp_n[1] = 0;
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_valid", 32'(res_valid1), 32'd0);
    chk("mid_rst_any_jump", 32'(any_jump1), 32'd0);
    chk("mid_rst_move", res_move1, 32'd0);
    chk("mid_rst_jump", res_jump1, 32'd0);
    chk("mid_rst_busy0", 32'(busy0), 32'd0);
    step();
    own = 32'h1; opp = '0;
    run_pass(0, 1'b0);
    chk("post_rst_done_cycle", 32'(last_cyc[1]), 32'd13);
    chk("post_rst_d1_move", got[1][1].mv, 32'h10);

    // Randomized passes with the direction-dependent shifter.
    stub = 1'b0;
    for (int k = 0; k < 40; k++) begin
      own    = $urandom;
      opp    = $urandom & ~own;
      kings  = $urandom & own;
      player = 1'($urandom_range(0, 1));
      if (k % 8 == 0) own = '0;
      run_pass((k % 3 == 0) ? 0 : 1, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
